// File: rtl/rgbstream_gen.sv
// rgbstream_gen: raster timing generator that emits one registered RGB stream word per pixel clock.
module rgbstream_gen #(
    parameter int unsigned hactive  = 640,
    parameter int unsigned hfp      = 16,
    parameter int unsigned hsw      = 96,
    parameter int unsigned hbp      = 48,
    parameter int unsigned vactive  = 480,
    parameter int unsigned vfp      = 10,
    parameter int unsigned vsw      = 2,
    parameter int unsigned vbp      = 33,
    parameter logic [2:0]  color_bg = 3'b000
) (
    input  logic        px_clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [25:0] RGBStr_o,
    output logic        line_o,
    output logic        frame_o
);

    localparam int unsigned CNT_W  = 10;
    localparam int unsigned WORD_W = 26;
    localparam int unsigned HT     = hactive + hfp + hsw + hbp;
    localparam int unsigned VT     = vactive + vfp + vsw + vbp;

    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(hactive);
    localparam logic [CNT_W-1:0] H_SYNC_S = CNT_W'(hactive + hfp);
    localparam logic [CNT_W-1:0] H_SYNC_E = CNT_W'(hactive + hfp + hsw);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(HT - 1);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(vactive);
    localparam logic [CNT_W-1:0] V_SYNC_S = CNT_W'(vactive + vfp);
    localparam logic [CNT_W-1:0] V_SYNC_E = CNT_W'(vactive + vfp + vsw);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(VT - 1);

    // Idle word: sync lines deasserted (high), everything else zero.
    localparam logic [WORD_W-1:0] RESET_WORD = WORD_W'(26'h0000006);

    // Stream word layout, MSB first: {B,G,R}, XC, YC, HS, VS, Active.
    typedef struct packed {
        logic [2:0]       rgb;
        logic [CNT_W-1:0] xc;
        logic [CNT_W-1:0] yc;
        logic             hs;
        logic             vs;
        logic             active;
    } stream_word_t;

    logic [CNT_W-1:0] hc;
    logic [CNT_W-1:0] vc;
    logic             hc_last_c;
    logic             vc_last_c;
    logic             active_c;
    stream_word_t     word_c;

    // Decode the current count position into a stream word.
    always_comb begin
        hc_last_c     = (hc == H_LAST);
        vc_last_c     = (vc == V_LAST);
        active_c      = (hc < H_ACT) && (vc < V_ACT);
        word_c        = '0;
        word_c.rgb    = active_c ? color_bg : 3'b000;
        word_c.xc     = hc;
        word_c.yc     = vc;
        word_c.hs     = !((hc >= H_SYNC_S) && (hc < H_SYNC_E));
        word_c.vs     = !((vc >= V_SYNC_S) && (vc < V_SYNC_E));
        word_c.active = active_c;
    end

    // Horizontal counter: advances on every enabled cycle, wraps at end of line.
    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            hc <= '0;
        end else if (en) begin
            hc <= hc_last_c ? '0 : hc + CNT_W'(1);
        end
    end

    // Vertical counter: advances when the line wraps, wraps at end of frame.
    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            vc <= '0;
        end else if (en && hc_last_c) begin
            vc <= vc_last_c ? '0 : vc + CNT_W'(1);
        end
    end

    // Output registers: word and strobes only update on enabled cycles so they hold together.
    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            RGBStr_o <= RESET_WORD;
            line_o   <= 1'b0;
            frame_o  <= 1'b0;
        end else if (en) begin
            RGBStr_o <= word_c;
            line_o   <= hc_last_c;
            frame_o  <= hc_last_c && vc_last_c;
        end
    end

endmodule

// File: tb/tb_rgbstream_gen.sv
// tb_rgbstream_gen: checks the default and a tiny-timing rgbstream_gen against a pixel-index reference model.
module tb_rgbstream_gen;

    localparam int D_TOT = 800 * 525;
    localparam int S_TOT = 7 * 5;

    typedef struct {
        int k;
        int xc;
        int yc;
        int act;
        int hs;
        int vs;
        int line;
    } vec_t;

    logic        px_clk;
    logic        rst_n;
    logic        en;
    logic [25:0] word_d;
    logic [25:0] word_s;
    logic        line_d;
    logic        frame_d;
    logic        line_s;
    logic        frame_s;

    rgbstream_gen dut_d (
        .px_clk  (px_clk),
        .rst_n   (rst_n),
        .en      (en),
        .RGBStr_o(word_d),
        .line_o  (line_d),
        .frame_o (frame_d)
    );

    rgbstream_gen #(
        .hactive (4),
        .hfp     (1),
        .hsw     (1),
        .hbp     (1),
        .vactive (2),
        .vfp     (1),
        .vsw     (1),
        .vbp     (1),
        .color_bg(3'b110)
    ) dut_s (
        .px_clk  (px_clk),
        .rst_n   (rst_n),
        .en      (en),
        .RGBStr_o(word_s),
        .line_o  (line_s),
        .frame_o (frame_s)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 0;

    always #5 px_clk = ~px_clk;

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_word(input string name, input logic [25:0] got, input logic [25:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%07h expected 0x%07h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected {frame, line, word} for linear pixel index n within a frame.
    function automatic logic [27:0] ref_word(input int n, input int ha, input int hf, input int hs,
                                             input int hb, input int va, input int vf, input int vs,
                                             input int vb, input logic [2:0] bg);
        int   ht;
        int   vt;
        int   x;
        int   y;
        logic act;
        logic hsn;
        logic vsn;
        logic ln;
        logic fr;
        ht  = ha + hf + hs + hb;
        vt  = va + vf + vs + vb;
        x   = n % ht;
        y   = n / ht;
        act = (x < ha) && (y < va);
        hsn = !((x >= ha + hf) && (x < ha + hf + hs));
        vsn = !((y >= va + vf) && (y < va + vf + vs));
        ln  = (x == ht - 1);
        fr  = ln && (y == vt - 1);
        return {fr, ln, (act ? bg : 3'b000), 10'(x), 10'(y), hsn, vsn, act};
    endfunction

    int          n_d;
    int          n_s;
    logic [27:0] exp_d;
    logic [27:0] exp_s;

    // Reference model: one pixel index per enabled edge, one-word latency.
    always @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            n_d   <= 0;
            n_s   <= 0;
            exp_d <= {2'b00, 26'h0000006};
            exp_s <= {2'b00, 26'h0000006};
        end else if (en) begin
            exp_d <= ref_word(n_d, 640, 16, 96, 48, 480, 10, 2, 33, 3'b000);
            exp_s <= ref_word(n_s, 4, 1, 1, 1, 2, 1, 1, 1, 3'b110);
            n_d   <= (n_d + 1) % D_TOT;
            n_s   <= (n_s + 1) % S_TOT;
        end
    end

    // Continuous comparison of both instances against the model.
    always @(negedge px_clk) begin
        if (chk_on) begin
            check_word("model_d_word", word_d, exp_d[25:0]);
            check_int("model_d_line", int'(line_d), int'(exp_d[26]));
            check_int("model_d_frame", int'(frame_d), int'(exp_d[27]));
            check_word("model_s_word", word_s, exp_s[25:0]);
            check_int("model_s_line", int'(line_s), int'(exp_s[26]));
            check_int("model_s_frame", int'(frame_s), int'(exp_s[27]));
        end
    end

    initial begin
        vec_t tbl[10];
        int   k;
        int   hs_low;
        int   act_lo;
        int   lines;
        int   rgb_cnt;
        int   act_s;
        int   vs_lo_s;
        int   hs_lo_s;
        int   ln_s;
        int   fr_s;
        int   fr_k;

        px_clk = 1'b0;
        rst_n  = 1'b0;
        en     = 1'b0;
        hs_low = 0;
        act_lo = 0;
        lines  = 0;

        // {k, xc, yc, act, hs, vs, line} for the default timing, k = enabled edges since release.
        tbl = '{
            '{1,    0,   0, 1, 1, 1, 0},
            '{640,  639, 0, 1, 1, 1, 0},
            '{641,  640, 0, 0, 1, 1, 0},
            '{656,  655, 0, 0, 1, 1, 0},
            '{657,  656, 0, 0, 0, 1, 0},
            '{752,  751, 0, 0, 0, 1, 0},
            '{753,  752, 0, 0, 1, 1, 0},
            '{800,  799, 0, 0, 1, 1, 1},
            '{801,  0,   1, 1, 1, 1, 0},
            '{1600, 799, 1, 0, 1, 1, 1}
        };

        repeat (3) @(negedge px_clk);
        chk_on = 1'b1;
        check_word("rst_word_d", word_d, 26'h0000006);
        check_int("rst_line_d", int'(line_d), 0);
        check_int("rst_frame_d", int'(frame_d), 0);
        check_word("rst_word_s", word_s, 26'h0000006);

        rst_n = 1'b1;
        en    = 1'b1;
        k     = 0;
        foreach (tbl[i]) begin
            while (k < tbl[i].k) begin
                @(negedge px_clk);
                k++;
                if (k <= 800) begin
                    if (!word_d[2]) hs_low++;
                    if (!word_d[0]) act_lo++;
                    if (line_d) lines++;
                end
            end
            check_int($sformatf("tbl%0d_xc", i), int'(word_d[22:13]), tbl[i].xc);
            check_int($sformatf("tbl%0d_yc", i), int'(word_d[12:3]), tbl[i].yc);
            check_int($sformatf("tbl%0d_act", i), int'(word_d[0]), tbl[i].act);
            check_int($sformatf("tbl%0d_hs", i), int'(word_d[2]), tbl[i].hs);
            check_int($sformatf("tbl%0d_vs", i), int'(word_d[1]), tbl[i].vs);
            check_int($sformatf("tbl%0d_line", i), int'(line_d), tbl[i].line);
        end
        check_int("line_hs_low_words", hs_low, 96);
        check_int("line_inactive_words", act_lo, 160);
        check_int("line_strobe_count", lines, 1);

        // Hold at end of line: word and strobe stay put, then resume into next line.
        en = 1'b0;
        for (int h = 0; h < 5; h++) begin
            @(negedge px_clk);
            check_int($sformatf("hold%0d_xc", h), int'(word_d[22:13]), 799);
            check_int($sformatf("hold%0d_yc", h), int'(word_d[12:3]), 1);
            check_int($sformatf("hold%0d_line", h), int'(line_d), 1);
        end
        en = 1'b1;
        @(negedge px_clk);
        check_int("resume_xc", int'(word_d[22:13]), 0);
        check_int("resume_yc", int'(word_d[12:3]), 2);
        check_int("resume_line", int'(line_d), 0);

        // Asynchronous reset mid-line.
        repeat (300) @(negedge px_clk);
        check_int("pre_rst_xc", int'(word_d[22:13]), 300);
        check_int("pre_rst_yc", int'(word_d[12:3]), 2);
        #2 rst_n = 1'b0;
        #1;
        check_word("async_rst_word_d", word_d, 26'h0000006);
        check_int("async_rst_line_d", int'(line_d), 0);
        check_int("async_rst_frame_d", int'(frame_d), 0);
        check_word("async_rst_word_s", word_s, 26'h0000006);
        @(negedge px_clk);
        check_word("held_rst_word_d", word_d, 26'h0000006);
        rst_n = 1'b1;

        // Tiny timing: one full frame of statistics.
        rgb_cnt = 0;
        act_s   = 0;
        vs_lo_s = 0;
        hs_lo_s = 0;
        ln_s    = 0;
        fr_s    = 0;
        fr_k    = 0;
        for (int kk = 1; kk <= 35; kk++) begin
            @(negedge px_clk);
            if (kk == 1) begin
                check_word("s_first_word", word_s, {3'b110, 10'd0, 10'd0, 3'b111});
                check_int("d_restart_xc", int'(word_d[22:13]), 0);
                check_int("d_restart_yc", int'(word_d[12:3]), 0);
                check_int("d_restart_act", int'(word_d[0]), 1);
            end
            if (word_s[25:23] == 3'b110) rgb_cnt++;
            if (word_s[0]) act_s++;
            if (!word_s[1]) vs_lo_s++;
            if (!word_s[2]) hs_lo_s++;
            if (line_s) ln_s++;
            if (frame_s) begin
                fr_s++;
                fr_k = kk;
            end
        end
        check_int("s_rgb_words", rgb_cnt, 8);
        check_int("s_active_words", act_s, 8);
        check_int("s_vs_low_words", vs_lo_s, 7);
        check_int("s_hs_low_words", hs_lo_s, 5);
        check_int("s_line_strobes", ln_s, 5);
        check_int("s_frame_strobes", fr_s, 1);
        check_int("s_frame_pos", fr_k, 35);
        check_int("s_frame_xc", int'(word_s[22:13]), 6);
        check_int("s_frame_yc", int'(word_s[12:3]), 4);
        check_int("s_frame_line", int'(line_s), 1);
        @(negedge px_clk);
        check_int("s_wrap_xc", int'(word_s[22:13]), 0);
        check_int("s_wrap_yc", int'(word_s[12:3]), 0);
        check_int("s_wrap_frame", int'(frame_s), 0);

        // Frame period of 35 cycles.
        fr_s = 0;
        fr_k = 0;
        for (int kk = 37; kk <= 70; kk++) begin
            @(negedge px_clk);
            if (frame_s) begin
                fr_s++;
                fr_k = kk;
            end
        end
        check_int("s_frame2_count", fr_s, 1);
        check_int("s_frame2_pos", fr_k, 70);

        // Reset while a frame strobe is showing: nothing survives.
        #2 rst_n = 1'b0;
        #1;
        check_int("rst_kill_frame_s", int'(frame_s), 0);
        check_int("rst_kill_line_s", int'(line_s), 0);
        check_word("rst_kill_word_s", word_s, 26'h0000006);
        @(negedge px_clk);
        rst_n = 1'b1;

        // Randomised enable pattern, checked by the model every cycle.
        for (int r = 0; r < 3000; r++) begin
            @(negedge px_clk);
            en = ($urandom_range(0, 3) != 0);
        end
        @(negedge px_clk);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
